multi_channel_memory_monitor: RTL and testbench
===============================================

# multi_channel_memory_monitor

Parametrised, multi-channel occupancy monitor for circular data buffers; the successor to the single-channel memory monitor. For each of NCH buffers it derives fill level from write/read addresses and wrap (round) counters. It classifies each buffer as normal, full, overflowed, underflowed or address-out-of-range, and keeps sticky error flags, an almost-full flag and a high-watermark per channel. It sits beside the event-buffer write/read controllers and feeds the status/slow-control register block.

## Interface
- ADDR_W, 15, buffer address width; also width of limit, usage and watermark
- ROUND_W, 10, wrap-counter width
- NCH, 4, number of monitored buffers (1..16)
- CH_W, derived, max(1, clog2(NCH)), channel-index width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_addr  in  NCH*ADDR_W  per-channel write address, channel c at bits [c*ADDR_W +: ADDR_W]
- rd_addr  in  NCH*ADDR_W  per-channel read address
- n_wr  in  NCH*ROUND_W  per-channel write wrap count
- n_rd  in  NCH*ROUND_W  per-channel read wrap count
- limit  in  ADDR_W  buffer depth in words, shared by all channels, must be ≥1
- afull_thresh  in  ADDR_W  almost-full threshold, shared
- clear  in  1  one-cycle pulse that clears sticky flags and watermarks
- usage  out  NCH*ADDR_W  registered fill level per channel
- watermark  out  NCH*ADDR_W  maximum usage since reset/clear
- almost_full  out  NCH  usage ≥ afull_thresh (non-sticky)
- overflow, underflow, range_err  out  NCH each  sticky per-channel error flags
- error  out  1  OR of all sticky flags, registered
- upd_valid  out  1  a channel's outputs were updated this cycle
- upd_ch  out  CH_W  index of the channel updated

## Operation
- Scan counter ch_idx steps 0..NCH-1 every cycle and wraps; one channel is evaluated per cycle.
- Stage 1 registers the selected channel's wr, rd, n_wr, n_rd and the index.
- Stage 2 classifies and writes that channel's outputs.
- Classification:
  - d = (n_wr - n_rd) mod 2^ROUND_W, read as two's complement.
  - RANGE: wr ≥ limit or rd ≥ limit. Sets range_err; usage is held.
  - UNDERFLOW: d < 0, or d = 0 with wr < rd. Sets underflow; usage = 0.
  - NORMAL: d = 0 with wr ≥ rd. usage = wr - rd.
  - WRAPPED: d = 1 with wr < rd. usage = limit - rd + wr.
  - FULL: d = 1 with wr = rd. usage = limit. This is legal; no error.
  - OVERFLOW: d = 1 with wr > rd, or d ≥ 2. Sets overflow; usage = limit.
  - Priority is RANGE > UNDERFLOW > OVERFLOW > FULL/WRAPPED/NORMAL.
- All arithmetic is ADDR_W-bit unsigned. limit - rd + wr never exceeds limit because rd > wr.
- almost_full[c] = (new usage ≥ afull_thresh). With afull_thresh = 0 it is always set.
- watermark[c] = max(watermark[c], new usage), updated on every evaluation of c.
- clear: zeroes all sticky flags and watermarks on the next edge. It does not touch usage, almost_full or the pipeline.
  - If clear coincides with a stage-2 update of channel c, the update wins for c: a newly set flag stays set, and watermark[c] = new usage.
- error = OR of all overflow, underflow and range_err bits, registered one cycle after the flags.

## Timing
- Reset values:
  - all outputs 0; upd_valid = 0, upd_ch = 0
  - ch_idx = 0; pipeline valid bits = 0
- Inputs of channel c are sampled on the edge at which ch_idx == c. Outputs for c update on the following edge (2-cycle latency from sample to output).
- upd_valid/upd_ch are asserted in the same cycle the outputs change.
- error follows one cycle later.
- Refresh period per channel = NCH cycles. First upd_valid occurs 2 cycles after reset deasserts.
- Inputs are treated as quasi-static samples. No handshake; no coherence between wr and rd is assumed beyond the sampling edge.
- Reset mid-scan: pipeline contents are discarded, no partial update is issued, and the scan restarts at channel 0.
- NCH = 1: ch_idx stays 0 and the channel refreshes every cycle.

## Structure
- Package memmon_pkg holds:
  - enum occ_class_t {OCC_NORMAL, OCC_WRAPPED, OCC_FULL, OCC_OVERFLOW, OCC_UNDERFLOW, OCC_RANGE}
  - default widths
  - function clog2_min1
- Sub-module occupancy_classifier (combinational, parametrised by ADDR_W and ROUND_W):
  - inputs: wr, rd, n_wr, n_rd, limit
  - outputs: occ_class_t, usage
  - It is instantiated once in stage 2 and is unit-testable on its own.
- Top level holds the scan counter, stage-1 registers, the per-channel output register arrays, watermark/flag logic and the error OR.

## Test plan
- NCH=4, limit=1000, ch0 wr=300 rd=100 n_wr=n_rd=5 -> usage[0]=200, no flags, upd_ch=0 two cycles after sampling.
- ch1 wr=50 rd=900 n_wr=6 n_rd=5 -> usage[1]=150. Then wr=rd=900 with the same rounds -> usage[1]=1000, overflow[1]=0.
- ch2 wr=100 rd=50 n_wr=7 n_rd=5 -> overflow[2]=1, usage[2]=1000, error=1 the next cycle. Restoring legal inputs keeps overflow[2]=1 until clear.
- ch3 n_wr=0 n_rd=1023 (d=+1 mod 1024), wr=10 rd=20 -> WRAPPED, usage[3]=990. Then wr=20 rd=10 with n_wr=n_rd -> usage[3]=10, watermark[3]=990.
- ch0 rd=1200 -> range_err[0]=1 and usage[0] unchanged. Pulse clear on the same cycle as a ch0 overflow update -> overflow[0] remains 1, other channels' flags clear.
- Assert reset mid-scan at ch_idx=2 -> all outputs 0 next edge. First post-reset upd_ch=0, and no stale update of channel 2 appears.

Source files
------------

// File: rtl/multi_channel_memory_monitor_pkg.sv
// ---------------------------------------------------------------------------
// memmon_pkg
// Shared types and defaults for the multi-channel memory monitor.
//   occ_class_t  : occupancy classification of one circular buffer
//   DEF_*        : default widths / channel count
//   clog2_min1() : channel-index width, never less than one bit
// ---------------------------------------------------------------------------
package memmon_pkg;

    localparam int DEF_ADDR_W  = 15;
    localparam int DEF_ROUND_W = 10;
    localparam int DEF_NCH     = 4;

    typedef enum logic [2:0] {
        OCC_NORMAL,
        OCC_WRAPPED,
        OCC_FULL,
        OCC_OVERFLOW,
        OCC_UNDERFLOW,
        OCC_RANGE
    } occ_class_t;

    // A single channel still needs a one-bit index so port widths stay legal.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/occupancy_classifier.sv
// ---------------------------------------------------------------------------
// occupancy_classifier
// Combinational classifier for one circular buffer.
//   wr, rd      in  write / read address
//   n_wr, n_rd  in  write / read wrap counters
//   limit       in  buffer depth in words
//   occ_class   out classification (RANGE > UNDERFLOW > OVERFLOW > legal)
//   usage       out fill level; don't-care for OCC_RANGE (caller holds it)
// ---------------------------------------------------------------------------
module occupancy_classifier
    import memmon_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ROUND_W = DEF_ROUND_W
) (
    input  logic [ADDR_W-1:0]  wr,
    input  logic [ADDR_W-1:0]  rd,
    input  logic [ROUND_W-1:0] n_wr,
    input  logic [ROUND_W-1:0] n_rd,
    input  logic [ADDR_W-1:0]  limit,
    output occ_class_t         occ_class,
    output logic [ADDR_W-1:0]  usage
);

    // Round difference read as two's complement, decoded into the few
    // cases the classification cares about.
    logic [ROUND_W-1:0] d;
    logic               d_neg, d_zero, d_one, d_ge2;

    assign d      = n_wr - n_rd;
    assign d_neg  = d[ROUND_W-1];
    assign d_zero = (d == '0);
    assign d_one  = (d == ROUND_W'(1));
    assign d_ge2  = !d_neg && !d_zero && !d_one;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        occ_class = OCC_NORMAL;
        usage     = wr - rd;
        if (wr >= limit || rd >= limit) begin
            occ_class = OCC_RANGE;
            usage     = '0;
        end else if (d_neg || (d_zero && wr < rd)) begin
            occ_class = OCC_UNDERFLOW;
            usage     = '0;
        end else if (d_ge2 || (d_one && wr > rd)) begin
            occ_class = OCC_OVERFLOW;
            usage     = limit;
        end else if (d_one && wr == rd) begin
            occ_class = OCC_FULL;
            usage     = limit;
        end else if (d_one) begin
            // rd > wr here, so the result never exceeds limit.
            occ_class = OCC_WRAPPED;
            usage     = limit - rd + wr;
        end
    end

endmodule

// File: rtl/multi_channel_memory_monitor.sv
// ---------------------------------------------------------------------------
// multi_channel_memory_monitor
// Round-robin occupancy monitor for NCH circular buffers. One channel is
// sampled per cycle (stage 1) and classified/written back the next (stage 2).
//   clk, reset          system clock, synchronous active-high reset
//   wr_addr, rd_addr    per-channel addresses, channel c at [c*ADDR_W +: ADDR_W]
//   n_wr, n_rd          per-channel wrap counters, [c*ROUND_W +: ROUND_W]
//   limit, afull_thresh shared buffer depth and almost-full threshold
//   clear               pulse: zero sticky flags and watermarks
//   usage, watermark    per-channel fill level and its maximum
//   almost_full         per-channel usage >= afull_thresh
//   overflow, underflow, range_err  sticky per-channel error flags
//   error               registered OR of all sticky flags
//   upd_valid, upd_ch   a channel's outputs changed this cycle, and which
// ---------------------------------------------------------------------------
module multi_channel_memory_monitor
    import memmon_pkg::*;
#(
    parameter int  ADDR_W  = DEF_ADDR_W,
    parameter int  ROUND_W = DEF_ROUND_W,
    parameter int  NCH     = DEF_NCH,
    localparam int CH_W    = clog2_min1(NCH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH*ADDR_W-1:0]   wr_addr,
    input  logic [NCH*ADDR_W-1:0]   rd_addr,
    input  logic [NCH*ROUND_W-1:0]  n_wr,
    input  logic [NCH*ROUND_W-1:0]  n_rd,
    input  logic [ADDR_W-1:0]       limit,
    input  logic [ADDR_W-1:0]       afull_thresh,
    input  logic                    clear,
    output logic [NCH*ADDR_W-1:0]   usage,
    output logic [NCH*ADDR_W-1:0]   watermark,
    output logic [NCH-1:0]          almost_full,
    output logic [NCH-1:0]          overflow,
    output logic [NCH-1:0]          underflow,
    output logic [NCH-1:0]          range_err,
    output logic                    error,
    output logic                    upd_valid,
    output logic [CH_W-1:0]         upd_ch
);

    logic [ADDR_W-1:0]  wr_arr [NCH];
    logic [ADDR_W-1:0]  rd_arr [NCH];
    logic [ROUND_W-1:0] nwr_arr [NCH];
    logic [ROUND_W-1:0] nrd_arr [NCH];
    logic [ADDR_W-1:0]  usage_q [NCH];
    logic [ADDR_W-1:0]  wm_q [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign wr_arr[c]  = wr_addr[c*ADDR_W +: ADDR_W];
        assign rd_arr[c]  = rd_addr[c*ADDR_W +: ADDR_W];
        assign nwr_arr[c] = n_wr[c*ROUND_W +: ROUND_W];
        assign nrd_arr[c] = n_rd[c*ROUND_W +: ROUND_W];
        assign usage[c*ADDR_W +: ADDR_W]     = usage_q[c];
        assign watermark[c*ADDR_W +: ADDR_W] = wm_q[c];
    end

    // Scan counter and stage-1 sample registers.
    logic [CH_W-1:0]    ch_idx;
    logic               s1_valid;
    logic [CH_W-1:0]    s1_ch;
    logic [ADDR_W-1:0]  s1_wr, s1_rd;
    logic [ROUND_W-1:0] s1_nwr, s1_nrd;

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_idx   <= '0;
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_wr    <= '0;
            s1_rd    <= '0;
            s1_nwr   <= '0;
            s1_nrd   <= '0;
        end else begin
            ch_idx   <= (ch_idx == CH_W'(NCH-1)) ? '0 : ch_idx + 1'b1;
            s1_valid <= 1'b1;
            s1_ch    <= ch_idx;
            s1_wr    <= wr_arr[ch_idx];
            s1_rd    <= rd_arr[ch_idx];
            s1_nwr   <= nwr_arr[ch_idx];
            s1_nrd   <= nrd_arr[ch_idx];
        end
    end

    // Stage 2: classify the sampled channel.
    occ_class_t        cls;
    logic [ADDR_W-1:0] cls_usage;
    logic [ADDR_W-1:0] new_usage;

    occupancy_classifier #(
        .ADDR_W  (ADDR_W),
        .ROUND_W (ROUND_W)
    ) u_classifier (
        .wr        (s1_wr),
        .rd        (s1_rd),
        .n_wr      (s1_nwr),
        .n_rd      (s1_nrd),
        .limit     (limit),
        .occ_class (cls),
        .usage     (cls_usage)
    );

    // An out-of-range sample carries no usable fill level: keep the old one.
    assign new_usage = (cls == OCC_RANGE) ? usage_q[s1_ch] : cls_usage;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the per-channel arrays are architectural outputs with a
            // defined reset value, so they are reset like any other register.
            for (int c = 0; c < NCH; c++) begin
                usage_q[c] <= '0;
                wm_q[c]    <= '0;
            end
            almost_full <= '0;
            overflow    <= '0;
            underflow   <= '0;
            range_err   <= '0;
            error       <= 1'b0;
            upd_valid   <= 1'b0;
            upd_ch      <= '0;
        end else begin
            error     <= |{overflow, underflow, range_err};
            upd_valid <= s1_valid;

            if (clear) begin
                overflow  <= '0;
                underflow <= '0;
                range_err <= '0;
                for (int c = 0; c < NCH; c++) begin
                    wm_q[c] <= '0;
                end
            end

            // The channel update comes after the bulk clear so that, for the
            // updated channel, these later assignments take precedence.
            if (s1_valid) begin
                upd_ch                <= s1_ch;
                usage_q[s1_ch]        <= new_usage;
                almost_full[s1_ch]    <= (new_usage >= afull_thresh);
                overflow[s1_ch]       <= (overflow[s1_ch]  & ~clear) | (cls == OCC_OVERFLOW);
                underflow[s1_ch]      <= (underflow[s1_ch] & ~clear) | (cls == OCC_UNDERFLOW);
                range_err[s1_ch]      <= (range_err[s1_ch] & ~clear) | (cls == OCC_RANGE);
                if (clear || new_usage > wm_q[s1_ch]) begin
                    wm_q[s1_ch] <= new_usage;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_memory_monitor.sv
// ---------------------------------------------------------------------------
// tb_multi_channel_memory_monitor
// Directed scenarios followed by randomized traffic, checked every cycle
// against a word-count reference model of each buffer.
// ---------------------------------------------------------------------------
module tb_multi_channel_memory_monitor;
    import memmon_pkg::*;

    localparam int ADDR_W  = 15;
    localparam int ROUND_W = 10;
    localparam int NCH     = 4;
    localparam int CH_W    = 2;
    localparam int RMOD    = 1 << ROUND_W;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NCH*ADDR_W-1:0]  wr_addr, rd_addr;
    logic [NCH*ROUND_W-1:0] n_wr, n_rd;
    logic [ADDR_W-1:0]      limit, afull_thresh;
    logic                   clear;
    logic [NCH*ADDR_W-1:0]  usage, watermark;
    logic [NCH-1:0]         almost_full, overflow, underflow, range_err;
    logic                   error, upd_valid;
    logic [CH_W-1:0]        upd_ch;

    multi_channel_memory_monitor #(
        .ADDR_W (ADDR_W), .ROUND_W (ROUND_W), .NCH (NCH)
    ) dut (
        .clk (clk), .reset (reset),
        .wr_addr (wr_addr), .rd_addr (rd_addr), .n_wr (n_wr), .n_rd (n_rd),
        .limit (limit), .afull_thresh (afull_thresh), .clear (clear),
        .usage (usage), .watermark (watermark), .almost_full (almost_full),
        .overflow (overflow), .underflow (underflow), .range_err (range_err),
        .error (error), .upd_valid (upd_valid), .upd_ch (upd_ch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-buffer state plus the sample awaiting evaluation.
    int m_usage [NCH];
    int m_wm    [NCH];
    bit m_af    [NCH];
    bit m_ovf   [NCH];
    bit m_udf   [NCH];
    bit m_rng   [NCH];
    bit m_err, m_upd_valid;
    int m_upd_ch;
    int scan;
    bit p_valid;
    int p_ch, p_wr, p_rd, p_nwr, p_nrd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int u_of(input int c);
        return int'(usage[c*ADDR_W +: ADDR_W]);
    endfunction

    function automatic int wm_of(input int c);
        return int'(watermark[c*ADDR_W +: ADDR_W]);
    endfunction

    task automatic model_edge();
        bit new_err;
        int d, lim, words, nu;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_usage[c] = 0; m_wm[c] = 0; m_af[c] = 0;
                m_ovf[c] = 0; m_udf[c] = 0; m_rng[c] = 0;
            end
            m_err = 0; m_upd_valid = 0; m_upd_ch = 0;
            scan = 0; p_valid = 0;
            return;
        end
        new_err = 0;
        for (int c = 0; c < NCH; c++) new_err |= m_ovf[c] | m_udf[c] | m_rng[c];
        m_upd_valid = p_valid;
        if (clear) begin
            for (int c = 0; c < NCH; c++) begin
                m_ovf[c] = 0; m_udf[c] = 0; m_rng[c] = 0; m_wm[c] = 0;
            end
        end
        if (p_valid) begin
            // Signed wrap difference times depth plus address offset gives
            // the number of words held; its sign and size decide the class.
            d = ((p_nwr - p_nrd) % RMOD + RMOD) % RMOD;
            if (d >= RMOD / 2) d -= RMOD;
            lim   = int'(limit);
            words = d * lim + p_wr - p_rd;
            if (p_wr >= lim || p_rd >= lim) begin
                m_rng[p_ch] = 1; nu = m_usage[p_ch];
            end else if (words < 0) begin
                m_udf[p_ch] = 1; nu = 0;
            end else if (words > lim) begin
                m_ovf[p_ch] = 1; nu = lim;
            end else begin
                nu = words;
            end
            m_usage[p_ch] = nu;
            m_af[p_ch]    = (nu >= int'(afull_thresh));
            if (clear || nu > m_wm[p_ch]) m_wm[p_ch] = nu;
            m_upd_ch = p_ch;
        end
        p_valid = 1;
        p_ch  = scan;
        p_wr  = int'(wr_addr[scan*ADDR_W +: ADDR_W]);
        p_rd  = int'(rd_addr[scan*ADDR_W +: ADDR_W]);
        p_nwr = int'(n_wr[scan*ROUND_W +: ROUND_W]);
        p_nrd = int'(n_rd[scan*ROUND_W +: ROUND_W]);
        scan  = (scan + 1) % NCH;
        m_err = new_err;
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("usage%0d", c), 64'(u_of(c)), 64'(m_usage[c]));
            check($sformatf("wm%0d", c), 64'(wm_of(c)), 64'(m_wm[c]));
            check($sformatf("afull%0d", c), 64'(almost_full[c]), 64'(m_af[c]));
            check($sformatf("ovf%0d", c), 64'(overflow[c]), 64'(m_ovf[c]));
            check($sformatf("udf%0d", c), 64'(underflow[c]), 64'(m_udf[c]));
            check($sformatf("rng%0d", c), 64'(range_err[c]), 64'(m_rng[c]));
        end
        check("error", 64'(error), 64'(m_err));
        check("upd_valid", 64'(upd_valid), 64'(m_upd_valid));
        if (m_upd_valid) check("upd_ch", 64'(upd_ch), 64'(m_upd_ch));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_ch(input int c, input int wr, input int rd, input int nw, input int nr);
        wr_addr[c*ADDR_W +: ADDR_W]   = ADDR_W'(wr);
        rd_addr[c*ADDR_W +: ADDR_W]   = ADDR_W'(rd);
        n_wr[c*ROUND_W +: ROUND_W]    = ROUND_W'(nw);
        n_rd[c*ROUND_W +: ROUND_W]    = ROUND_W'(nr);
    endtask

    task automatic wait_upd(input int c);
        bit found = 0;
        for (int i = 0; i < 4 * NCH && !found; i++) begin
            step();
            if (upd_valid && int'(upd_ch) == c) found = 1;
        end
        check($sformatf("wait_upd%0d", c), 64'(found), 64'd1);
    endtask

    task automatic rand_ch(input int c);
        int lim, wr, rd, nw, dd, k;
        lim = int'(limit);
        wr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(lim, 32767)) : int'($urandom_range(0, lim - 1));
        rd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(lim, 32767)) : int'($urandom_range(0, lim - 1));
        if ($urandom_range(0, 4) == 0) rd = wr;
        nw = int'($urandom_range(0, RMOD - 1));
        k  = int'($urandom_range(0, 9));
        dd = (k < 1) ? -1 : (k < 4) ? 0 : (k < 8) ? 1 : int'($urandom_range(2, 600));
        set_ch(c, wr, rd, nw, (nw - dd + RMOD) % RMOD);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset = 1; clear = 0;
        limit = ADDR_W'(1000); afull_thresh = ADDR_W'(800);
        wr_addr = '0; rd_addr = '0; n_wr = '0; n_rd = '0;
        set_ch(0, 300, 100, 5, 5);

        // Reset state.
        run(3);
        check("rst_usage", 64'(usage), 64'd0);
        check("rst_wm", 64'(watermark), 64'd0);
        check("rst_flags", 64'({almost_full, overflow, underflow, range_err}), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_upd", 64'({upd_valid, upd_ch}), 64'd0);

        // First update lands two edges after release, on channel 0.
        reset = 0;
        step();
        check("first_edge_no_upd", 64'(upd_valid), 64'd0);
        step();
        check("first_upd_valid", 64'(upd_valid), 64'd1);
        check("first_upd_ch", 64'(upd_ch), 64'd0);
        check("ch0_normal_usage", 64'(u_of(0)), 64'd200);
        check("ch0_no_flags", 64'({overflow[0], underflow[0], range_err[0]}), 64'd0);

        // Wrapped, then exactly full.
        set_ch(1, 50, 900, 6, 5);
        run(NCH + 2);
        check("ch1_wrapped_usage", 64'(u_of(1)), 64'd150);
        set_ch(1, 900, 900, 6, 5);
        run(NCH + 2);
        check("ch1_full_usage", 64'(u_of(1)), 64'd1000);
        check("ch1_full_no_ovf", 64'(overflow[1]), 64'd0);
        check("ch1_full_afull", 64'(almost_full[1]), 64'd1);

        // Overflow is sticky and raises error.
        set_ch(2, 100, 50, 7, 5);
        run(NCH + 2);
        check("ch2_ovf", 64'(overflow[2]), 64'd1);
        check("ch2_ovf_usage", 64'(u_of(2)), 64'd1000);
        check("ch2_error", 64'(error), 64'd1);
        set_ch(2, 0, 0, 5, 5);
        run(NCH + 2);
        check("ch2_ovf_sticky", 64'(overflow[2]), 64'd1);
        check("ch2_legal_usage", 64'(u_of(2)), 64'd0);

        // Round counter wrap-around, then watermark retention.
        set_ch(3, 10, 20, 0, 1023);
        run(NCH + 2);
        check("ch3_wrap_usage", 64'(u_of(3)), 64'd990);
        set_ch(3, 20, 10, 0, 0);
        run(NCH + 2);
        check("ch3_usage", 64'(u_of(3)), 64'd10);
        check("ch3_wm", 64'(wm_of(3)), 64'd990);
        check("ch3_afull_off", 64'(almost_full[3]), 64'd0);

        // Range error holds usage.
        set_ch(0, 300, 1200, 5, 5);
        run(NCH + 2);
        check("ch0_range", 64'(range_err[0]), 64'd1);
        check("ch0_range_usage_held", 64'(u_of(0)), 64'd200);

        // Clear coinciding with a ch0 overflow update.
        wait_upd(0);
        set_ch(0, 100, 50, 7, 5);
        wait_upd(NCH - 1);
        clear = 1;
        step();
        clear = 0;
        check("clr_upd_ch", 64'(upd_ch), 64'd0);
        check("clr_ch0_ovf_kept", 64'(overflow[0]), 64'd1);
        check("clr_ch0_rng_cleared", 64'(range_err[0]), 64'd0);
        check("clr_ch2_ovf_cleared", 64'(overflow[2]), 64'd0);
        check("clr_ch0_wm", 64'(wm_of(0)), 64'd1000);
        check("clr_ch3_wm", 64'(wm_of(3)), 64'd0);
        run(2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: limit = ADDR_W'(1);
                    1: limit = ADDR_W'(37);
                    2: limit = ADDR_W'(1000);
                    default: limit = ADDR_W'(32767);
                endcase
                afull_thresh = ADDR_W'($urandom_range(0, int'(limit)));
            end
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) == 0) rand_ch(c);
            end
            clear = ($urandom_range(0, 19) == 0);
            step();
        end
        clear = 0;

        // Reset while the scan is at channel 2.
        for (int i = 0; i < NCH && scan != 2; i++) step();
        check("scan_at_2", 64'(scan), 64'd2);
        reset = 1;
        step();
        check("mid_rst_usage", 64'(usage), 64'd0);
        check("mid_rst_flags", 64'({almost_full, overflow, underflow, range_err}), 64'd0);
        check("mid_rst_upd", 64'(upd_valid), 64'd0);
        reset = 0;
        step();
        check("post_rst_no_stale", 64'(upd_valid), 64'd0);
        step();
        check("post_rst_upd_valid", 64'(upd_valid), 64'd1);
        check("post_rst_upd_ch", 64'(upd_ch), 64'd0);
        run(2 * NCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
